// File: rtl/frame_scheduler_pkg.sv
// Shared constants, state encoding and raster-extent helpers for the frame scheduler.
package frame_scheduler_pkg;
    localparam int X_SIZE_DEF = 3840;
    localparam int Y_SIZE_DEF = 2160;
    localparam int CW_DEF     = 16;
    localparam int FCW_DEF    = 16;
    localparam int SHIFT_W    = 5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SYNC = 2'd1,
        ST_RUN  = 2'd2
    } state_e;

    // Raster is centred on the origin; y counts down from the top line.
    function automatic int x_min(input int xs);
        return -(xs / 2);
    endfunction

    function automatic int x_max(input int xs);
        return xs / 2 - 1;
    endfunction

    function automatic int y_max(input int ys);
        return ys / 2;
    endfunction

    function automatic int y_min(input int ys);
        return 1 - ys / 2;
    endfunction
endpackage

// File: rtl/frame_scheduler_stream_skid_buf.sv
// Two-entry ready/valid register slice; in_ready comes straight from a flop so upstream sees no comb path.
module stream_skid_buf #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         flush_i,
    input  logic [W-1:0] in_data_i,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    output logic [W-1:0] out_data_o,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic         busy_o
);
    logic [W-1:0] out_data_q;
    logic [W-1:0] skid_data_q;
    logic         out_valid_q;
    logic         skid_valid_q;

    always_ff @(posedge clk) begin
        if (flush_i) begin
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            out_data_q   <= '0;
        end else if (!out_valid_q || out_ready_i) begin
            if (skid_valid_q) begin
                out_data_q   <= skid_data_q;
                out_valid_q  <= 1'b1;
                skid_valid_q <= 1'b0;
            end else begin
                out_valid_q <= in_valid_i;
                if (in_valid_i) begin
                    out_data_q <= in_data_i;
                end
            end
        end else if (in_valid_i && !skid_valid_q) begin
            // Output stalled: park the beat that was already promised a slot.
            skid_data_q  <= in_data_i;
            skid_valid_q <= 1'b1;
        end
    end

    assign in_ready_o  = !skid_valid_q;
    assign out_data_o  = out_data_q;
    assign out_valid_o = out_valid_q;
    assign busy_o      = out_valid_q || skid_valid_q;
endmodule

// File: rtl/frame_scheduler.sv
// Gates the raster coordinate stream into the pixel pipeline on whole-frame boundaries,
// tags SOF/EOL/EOF and swaps view parameters only between frames.
module frame_scheduler
    import frame_scheduler_pkg::*;
#(
    parameter int X_SIZE = X_SIZE_DEF,
    parameter int Y_SIZE = Y_SIZE_DEF,
    parameter int CW     = CW_DEF,
    parameter int FCW    = FCW_DEF
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic signed [CW-1:0] in_x,
    input  logic signed [CW-1:0] in_y,
    input  logic                 in_lastx,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic signed [CW-1:0] out_x,
    output logic signed [CW-1:0] out_y,
    output logic                 out_sof,
    output logic                 out_eol,
    output logic                 out_eof,
    output logic                 out_valid,
    input  logic                 out_ready,
    input  logic                 cmd_start,
    input  logic                 cmd_stop,
    input  logic                 single_mode,
    input  logic                 cfg_wr,
    input  logic signed [CW-1:0] cfg_off_x,
    input  logic signed [CW-1:0] cfg_off_y,
    input  logic [SHIFT_W-1:0]   cfg_shift,
    output logic signed [CW-1:0] act_off_x,
    output logic signed [CW-1:0] act_off_y,
    output logic [SHIFT_W-1:0]   act_shift,
    output logic                 busy,
    output logic                 frame_done,
    output logic [FCW-1:0]       frame_count
);
    localparam int PW = 2 * CW + 3;
    localparam logic signed [CW-1:0] X_MIN = CW'(x_min(X_SIZE));
    localparam logic signed [CW-1:0] Y_MAX = CW'(y_max(Y_SIZE));
    localparam logic signed [CW-1:0] Y_MIN = CW'(y_min(Y_SIZE));

    state_e               state_q;
    logic                 stop_pend_q;
    logic                 frame_done_q;
    logic [FCW-1:0]       frame_count_q;
    logic signed [CW-1:0] pend_off_x_q, pend_off_y_q, act_off_x_q, act_off_y_q;
    logic [SHIFT_W-1:0]   pend_shift_q, act_shift_q;
    logic signed [CW-1:0] off_x_d, off_y_d;
    logic [SHIFT_W-1:0]   shift_d;

    logic          sof_c, eof_c, in_hs, out_eof_hs;
    logic          sb_vin, sb_in_ready, sb_busy, sb_flush;
    logic [PW-1:0] sb_din, sb_dout;

    assign sof_c      = (in_x == X_MIN) && (in_y == Y_MAX);
    assign eof_c      = in_lastx && (in_y == Y_MIN);
    assign in_hs      = in_valid && in_ready;
    assign out_eof_hs = out_valid && out_ready && out_eof;

    // A write landing on the boundary edge must win over the older pending value.
    assign off_x_d = cfg_wr ? cfg_off_x : pend_off_x_q;
    assign off_y_d = cfg_wr ? cfg_off_y : pend_off_y_q;
    assign shift_d = cfg_wr ? cfg_shift : pend_shift_q;

    always_comb begin
        in_ready = 1'b0;
        case (state_q)
            // Hold the SOF beat upstream so RUN consumes it; wait out any drain first.
            ST_SYNC: in_ready = !sb_busy && !(in_valid && sof_c);
            ST_RUN:  in_ready = sb_in_ready;
            default: in_ready = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q       <= ST_IDLE;
            stop_pend_q   <= 1'b0;
            frame_done_q  <= 1'b0;
            frame_count_q <= '0;
            pend_off_x_q  <= '0;
            pend_off_y_q  <= '0;
            pend_shift_q  <= '0;
            act_off_x_q   <= '0;
            act_off_y_q   <= '0;
            act_shift_q   <= '0;
        end else begin
            if (cfg_wr) begin
                pend_off_x_q <= cfg_off_x;
                pend_off_y_q <= cfg_off_y;
                pend_shift_q <= cfg_shift;
            end
            frame_done_q <= out_eof_hs;
            if (out_eof_hs) begin
                frame_count_q <= frame_count_q + FCW'(1);
            end
            case (state_q)
                ST_IDLE: begin
                    stop_pend_q <= 1'b0;
                    if (cmd_start) begin
                        state_q <= ST_SYNC;
                    end
                end
                ST_SYNC: begin
                    if (cmd_stop) begin
                        state_q <= ST_IDLE;
                    end else if (in_valid && sof_c && !sb_busy) begin
                        state_q     <= ST_RUN;
                        act_off_x_q <= off_x_d;
                        act_off_y_q <= off_y_d;
                        act_shift_q <= shift_d;
                    end
                end
                ST_RUN: begin
                    if (cmd_stop) begin
                        stop_pend_q <= 1'b1;
                    end
                    if (in_hs && eof_c) begin
                        if (stop_pend_q || cmd_stop || single_mode) begin
                            state_q     <= ST_IDLE;
                            stop_pend_q <= 1'b0;
                        end else begin
                            act_off_x_q <= off_x_d;
                            act_off_y_q <= off_y_d;
                            act_shift_q <= shift_d;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign sb_flush = !resetn;
    assign sb_vin   = in_valid && (state_q == ST_RUN);
    assign sb_din   = {in_x, in_y, sof_c, in_lastx, eof_c};

    stream_skid_buf #(
        .W(PW)
    ) u_skid (
        .clk        (clk),
        .flush_i    (sb_flush),
        .in_data_i  (sb_din),
        .in_valid_i (sb_vin),
        .in_ready_o (sb_in_ready),
        .out_data_o (sb_dout),
        .out_valid_o(out_valid),
        .out_ready_i(out_ready),
        .busy_o     (sb_busy)
    );

    assign {out_x, out_y, out_sof, out_eol, out_eof} = sb_dout;

    assign act_off_x   = act_off_x_q;
    assign act_off_y   = act_off_y_q;
    assign act_shift   = act_shift_q;
    assign busy        = (state_q != ST_IDLE) || sb_busy;
    assign frame_done  = frame_done_q;
    assign frame_count = frame_count_q;
endmodule

// File: tb/tb_frame_scheduler.sv
// Bench for frame_scheduler on an 8x4 raster: scenario table plus hand-written cfg and reset sequences.
module tb_frame_scheduler;
    localparam int XS  = 8;
    localparam int YS  = 4;
    localparam int CW  = 16;
    localparam int FCW = 16;
    localparam int FB  = XS * YS;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic [CW-1:0] in_x = '0, in_y = '0;
    logic          in_lastx = 1'b0, in_valid = 1'b0, in_ready;
    logic [CW-1:0] out_x, out_y;
    logic          out_sof, out_eol, out_eof, out_valid;
    logic          out_ready = 1'b1;
    logic          cmd_start = 1'b0, cmd_stop = 1'b0, single_mode = 1'b0, cfg_wr = 1'b0;
    logic [CW-1:0] cfg_off_x = '0, cfg_off_y = '0;
    logic [4:0]    cfg_shift = '0;
    logic [CW-1:0] act_off_x, act_off_y;
    logic [4:0]    act_shift;
    logic          busy, frame_done;
    logic [FCW-1:0] frame_count;

    always #5 clk = ~clk;

    frame_scheduler #(.X_SIZE(XS), .Y_SIZE(YS), .CW(CW), .FCW(FCW)) dut (
        .clk(clk), .resetn(resetn),
        .in_x(in_x), .in_y(in_y), .in_lastx(in_lastx), .in_valid(in_valid), .in_ready(in_ready),
        .out_x(out_x), .out_y(out_y), .out_sof(out_sof), .out_eol(out_eol), .out_eof(out_eof),
        .out_valid(out_valid), .out_ready(out_ready),
        .cmd_start(cmd_start), .cmd_stop(cmd_stop), .single_mode(single_mode),
        .cfg_wr(cfg_wr), .cfg_off_x(cfg_off_x), .cfg_off_y(cfg_off_y), .cfg_shift(cfg_shift),
        .act_off_x(act_off_x), .act_off_y(act_off_y), .act_shift(act_shift),
        .busy(busy), .frame_done(frame_done), .frame_count(frame_count)
    );

    typedef struct packed {
        logic [CW-1:0] x;
        logic [CW-1:0] y;
        logic          sof;
        logic          eol;
        logic          eof;
    } beat_t;

    typedef struct {
        bit single;
        int stop_at;
        int start_idx;
        bit bp;
        bit both;
        int frames;
    } scen_t;

    beat_t exp_q[$];
    scen_t tbl[4];
    int    n_vec = 0, n_fail = 0;
    int    gen_idx = 0, out_cnt = 0, done_cnt = 0, exp_fc = 0, hs_cnt = 0;
    bit    gen_hs = 0, bp_on = 0, prev_stall = 0;
    beat_t held;

    function automatic beat_t beat_of(input int i);
        beat_t b;
        b.x   = CW'(-(XS / 2) + i % XS);
        b.y   = CW'(YS / 2 - i / XS);
        b.sof = (i == 0);
        b.eol = (i % XS == XS - 1);
        b.eof = (i == FB - 1);
        return b;
    endfunction

    task automatic check(input string nm, input logic [63:0] a, input logic [63:0] e);
        n_vec++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", nm, a, e);
        end
    endtask

    // One clock: drive inputs after the edge, sample and score on the falling edge.
    task automatic tick();
        beat_t b, e;
        @(posedge clk);
        #1;
        cmd_start = 1'b0;
        cmd_stop  = 1'b0;
        cfg_wr    = 1'b0;
        if (!resetn) begin
            gen_idx    = 0;
            gen_hs     = 0;
            prev_stall = 0;
        end else if (gen_hs) begin
            gen_idx = (gen_idx + 1) % FB;
        end
        b        = beat_of(gen_idx);
        in_x     = b.x;
        in_y     = b.y;
        in_lastx = b.eol;
        in_valid = 1'b1;
        if (bp_on) out_ready = ($urandom_range(0, 1) != 0);
        @(negedge clk);
        gen_hs = in_valid && in_ready;
        if (prev_stall)
            check("hold", {out_valid, out_x, out_y, out_sof, out_eol, out_eof}, {1'b1, held});
        prev_stall = out_valid && !out_ready;
        held = {out_x, out_y, out_sof, out_eol, out_eof};
        if (out_valid && out_ready) begin
            out_cnt++;
            if (exp_q.size() == 0) begin
                n_vec++;
                n_fail++;
                $display("FAIL extra_beat: got (%0d,%0d) want no beat", $signed(out_x), $signed(out_y));
            end else begin
                e = exp_q.pop_front();
                check("beat", {out_x, out_y, out_sof, out_eol, out_eof}, e);
            end
        end
        if (frame_done) done_cnt++;
    endtask

    task automatic check_reset_state();
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_tags", {out_sof, out_eol, out_eof}, 0);
        check("rst_busy", busy, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_frame_count", frame_count, 0);
        check("rst_act", {act_off_x, act_off_y, act_shift}, 0);
    endtask

    task automatic push_frames(input int n);
        for (int f = 0; f < n; f++)
            for (int i = 0; i < FB; i++) exp_q.push_back(beat_of(i));
    endtask

    task automatic run_scenario(input scen_t s);
        bit stopped = 0;
        single_mode = s.single;
        bp_on    = s.bp;
        gen_idx  = s.start_idx;
        gen_hs   = 0;
        out_cnt  = 0;
        done_cnt = 0;
        push_frames(s.frames);
        cmd_start = 1'b1;
        cmd_stop  = s.both;
        for (int c = 0; c < 4000; c++) begin
            tick();
            if (s.stop_at > 0 && !stopped && out_cnt >= s.stop_at) begin
                cmd_stop = 1'b1;
                stopped  = 1;
            end
            if (exp_q.size() == 0 && !busy) break;
        end
        bp_on     = 0;
        out_ready = 1'b1;
        repeat (40) tick();
        exp_fc += s.frames;
        check("missing_beats", exp_q.size(), 0);
        check("frames_done", done_cnt, s.frames);
        check("frame_count", frame_count, exp_fc);
        check("busy_after", busy, 0);
        check("in_ready_after", in_ready, 0);
        exp_q.delete();
    endtask

    initial begin
        bit wrote, stopped;
        // single, stop_at (output beat), start_idx, backpressure, start+stop together, frames
        tbl[0] = '{single: 1, stop_at: 0,  start_idx: 0,  bp: 0, both: 0, frames: 1};
        tbl[1] = '{single: 0, stop_at: 42, start_idx: 0,  bp: 0, both: 0, frames: 2};
        tbl[2] = '{single: 1, stop_at: 0,  start_idx: 21, bp: 0, both: 1, frames: 1};
        tbl[3] = '{single: 0, stop_at: 69, start_idx: 0,  bp: 1, both: 0, frames: 3};

        repeat (3) tick();
        check_reset_state();
        resetn = 1'b1;
        tick();

        for (int i = 0; i < 4; i++) run_scenario(tbl[i]);

        // View params written mid-frame 1 take effect exactly at the frame 2 SOF.
        single_mode = 1'b0;
        gen_idx = 0; gen_hs = 0; out_cnt = 0; done_cnt = 0; hs_cnt = 0;
        wrote = 0; stopped = 0;
        push_frames(2);
        cmd_start = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            tick();
            if (gen_hs) begin
                check("act_off_x", act_off_x, (hs_cnt < FB) ? 0 : 5);
                hs_cnt++;
            end
            if (!wrote && hs_cnt == 12) begin
                cfg_wr = 1'b1; cfg_off_x = 16'd5; cfg_off_y = 16'hFFFD; cfg_shift = 5'd7;
                wrote = 1;
            end
            if (!stopped && out_cnt >= 40) begin
                cmd_stop = 1'b1;
                stopped  = 1;
            end
            if (exp_q.size() == 0 && !busy) break;
        end
        repeat (10) tick();
        exp_fc += 2;
        check("cfg_missing", exp_q.size(), 0);
        check("cfg_frames", done_cnt, 2);
        check("cfg_count", frame_count, exp_fc);
        check("cfg_in_beats", hs_cnt, 2 * FB);
        check("cfg_off_y", act_off_y, 16'hFFFD);
        check("cfg_shift", act_shift, 7);
        exp_q.delete();

        // Reset in the middle of a backpressured frame.
        single_mode = 1'b0;
        gen_idx = 0; gen_hs = 0; out_cnt = 0;
        bp_on = 1;
        push_frames(1);
        cmd_start = 1'b1;
        for (int c = 0; c < 500; c++) begin
            tick();
            if (out_cnt >= 15) break;
        end
        check("reached_mid_frame", out_cnt, 15);
        bp_on = 0;
        out_ready = 1'b1;
        resetn = 1'b0;
        tick();
        check_reset_state();
        exp_q.delete();
        exp_fc = 0;
        resetn = 1'b1;
        tick();

        run_scenario(tbl[0]);
        check("act_after_reset", {act_off_x, act_off_y, act_shift}, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
